permutation_core: RTL
=====================

PERMUTATION_CORE -- requirements
Module: permutation_core

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous reset, active-high.
REQ-003 SHALL have port: start  input  1  request to begin a permutation; sampled only when ready=1.
REQ-004 SHALL have port: rounds_sel  input  1  0 = p8 (8 rounds), 1 = p12 (12 rounds); sampled with start.
REQ-005 SHALL have port: state_in  input  320 (ascon_state, s0..s4)  permutation input; sampled with start.
REQ-006 SHALL have port: ready  output  1  high when idle and able to accept start.
REQ-007 SHALL have port: state_out  output  320 (ascon_state)  internal state register, meaningful when valid=1.
REQ-008 SHALL have port: valid  output  1  permutation result available on state_out.
REQ-009 SHALL have port: ack  input  1  consumer accepts result; sampled only when valid=1.

Function
REQ-010 SHALL hold a 320-bit state register, a 4-bit round counter and an FSM with states IDLE, RUN, DONE.
REQ-011 IDLE: ready=1, valid=0; start=1 loads state_in into the register, latches rounds_sel, sets counter to 0 (p12) or 4 (p8), moves to RUN.
REQ-012 RUN: each cycle applies exactly one round to the register; ready=0, valid=0; start ignored.
REQ-013 One round SHALL be, in order: constant addition, substitution layer, linear layer.
REQ-014 Constant addition: s2[7:0] ^= c(i), c(i) = ((15-i)<<4) | i for counter i in 0..11 (0xf0, 0xe1, ... 0x4b); s0, s1, s3, s4 and s2[63:8] unchanged.
REQ-015 Substitution layer: standard Ascon 5-bit S-box applied bitsliced to all 64 columns, s0 = MSB of each 5-bit column input/output.
REQ-016 Linear layer: per-word rotate-xor, instantiated from the existing pl block (s0: 19/28, s1: 61/39, s2: 1/6, s3: 10/17, s4: 7/41).
REQ-017 Counter SHALL increment by 1 per RUN cycle; round applied at counter=11 is the last; FSM moves to DONE on that edge.
REQ-018 Latency: start accepted in cycle k -> valid=1 in cycle k+13 (p12) or k+9 (p8).
REQ-019 DONE: valid=1, ready=0, register frozen; ack=1 moves to IDLE on the next edge; valid stays high until then (no timeout).
REQ-020 start=1 in DONE (with or without ack) SHALL be ignored; a new start is accepted only in IDLE, earliest the cycle after ack.
REQ-021 state_out SHALL always equal the register; its contents outside DONE are unspecified to consumers.
REQ-022 rounds_sel and state_in changes outside the start cycle SHALL have no effect.
REQ-023 ack outside DONE SHALL be ignored.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, counter=0, register=0, valid=0, regardless of current state (including mid-RUN and DONE).
REQ-025 While rst=1, ready SHALL be 0 and start SHALL be ignored; ready=1 from the first cycle after rst deasserts.
REQ-026 rst SHALL take priority over start and ack in the same cycle.

Verification
REQ-027 p12 timing: reset, state_in=0, rounds_sel=1, start at cycle 0 -> ready=0 cycles 1..13, valid=1 at cycle 13, state_out matches software Ascon p12(0).
REQ-028 p8 timing/value: random state_in, rounds_sel=0, start at cycle 0 -> valid=1 at cycle 9, state_out equals model p8 (constants 0xb4..0x4b only).
REQ-029 Backpressure: hold ack=0 for 20 cycles after valid -> valid and state_out stable throughout; ack=1 -> ready=1 next cycle, valid=0.
REQ-030 Reset mid-operation: start p12, assert rst at cycle 5 -> cycle 6: valid=0, state_out=0, ready=0 while rst high, ready=1 after release; new start runs full 12 rounds.
REQ-031 Ignored inputs: start pulses and state_in/rounds_sel changes during RUN and DONE, ack during RUN -> result and timing identical to undisturbed run.
REQ-032 Back-to-back: ack and start driven high continuously -> each permutation completes, with exactly one IDLE cycle between a DONE and the next RUN, results match model for 1000 random vectors.

Source files
------------

// File: rtl/permutation_core_if.sv
// permutation_core_if -- request/result bundle for permutation_core.
//   start      : begin a permutation (taken only while ready=1)
//   rounds_sel : 0 = p8, 1 = p12, sampled with start
//   state_in   : 320-bit input state {s0,s1,s2,s3,s4}, s0 in [319:256]
//   ready      : core idle and able to accept start
//   state_out  : core state register, meaningful while valid=1
//   valid      : permutation result available on state_out
//   ack        : consumer accepts the result (taken only while valid=1)
// master = requester/consumer side, slave = permutation core side.
interface permutation_core_if;
    logic         start;
    logic         rounds_sel;
    logic [319:0] state_in;
    logic         ready;
    logic [319:0] state_out;
    logic         valid;
    logic         ack;

    modport master (
        output start, rounds_sel, state_in, ack,
        input  ready, state_out, valid
    );

    modport slave (
        input  start, rounds_sel, state_in, ack,
        output ready, state_out, valid
    );
endinterface

// File: rtl/permutation_core.sv
// permutation_core -- iterative Ascon permutation, one round per clock.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (clears state, forces IDLE)
//   bus : permutation_core_if.slave (start/rounds_sel/state_in in,
//         ready/state_out/valid out, ack in)
// p12 runs rounds 0..11, p8 runs rounds 4..11; the result is held in
// DONE until ack. State word order: s0 = [319:256] ... s4 = [63:0].
module permutation_core (
    input  logic               clk,
    input  logic               rst,
    permutation_core_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    fsm_t         fsm;
    logic [319:0] st;
    logic [3:0]   cnt;
    logic         idle_q;
    logic         valid_q;
    logic [319:0] round_out;

    // Per-word linear diffusion: x ^ (x >>> a) ^ (x >>> b).
    function automatic logic [63:0] pl(input logic [63:0] x,
                                       input int unsigned a,
                                       input int unsigned b);
        return x ^ ((x >> a) | (x << (64 - a)))
                 ^ ((x >> b) | (x << (64 - b)));
    endfunction

    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;

    always_comb begin
        x0 = st[319:256];
        x1 = st[255:192];
        x2 = st[191:128];
        x3 = st[127:64];
        x4 = st[63:0];
        // Round constant ((15-i)<<4)|i is simply {~i, i} for a 4-bit i.
        x2 = x2 ^ {56'd0, ~cnt, cnt};
        // Bitsliced 5-bit S-box across all 64 columns.
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        round_out = {pl(x0, 19, 28), pl(x1, 61, 39), pl(x2, 1, 6),
                     pl(x3, 10, 17), pl(x4, 7, 41)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm     <= IDLE;
            cnt     <= '0;
            st      <= '0;
            valid_q <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.start) begin
                        st     <= bus.state_in;
                        cnt    <= bus.rounds_sel ? 4'd0 : 4'd4;
                        idle_q <= 1'b0;
                        fsm    <= RUN;
                    end
                end
                RUN: begin
                    st  <= round_out;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd11) begin
                        valid_q <= 1'b1;
                        fsm     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        valid_q <= 1'b0;
                        idle_q  <= 1'b1;
                        fsm     <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    idle_q  <= 1'b1;
                    fsm     <= IDLE;
                end
            endcase
        end
    end

    // ready must drop while rst is held and rise in the first cycle
    // after release, so the registered idle flag is gated by rst.
    assign bus.ready     = idle_q & ~rst;
    assign bus.valid     = valid_q;
    assign bus.state_out = st;

endmodule
